mac_kern_sched: RTL and testbench



---
 rtl/mac_kern_sched_pkg.sv | 32 +++
 rtl/mac_kern_sched_tap_addr_gen.sv | 64 ++++++
 rtl/mac_kern_sched.sv | 154 +++++++++++++++
 tb/tb_mac_kern_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_kern_sched_pkg.sv
// Shared types for the conv MAC kernel scheduler.
// MAC_SCHED_PAD_EN selects same-size zero padding for 3x3 jobs.
package mac_kern_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    PAD_NONE = 1'b0,
    PAD_ZERO = 1'b1
  } pad_e;

  localparam int NUM_TAPS = 9;

`ifdef MAC_SCHED_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  // Kernel row of a 3x3 tap index (t/3).
  function automatic logic [1:0] tap_ky(input logic [3:0] t);
    if (t >= 4'd6)      return 2'd2;
    else if (t >= 4'd3) return 2'd1;
    else                return 2'd0;
  endfunction

endpackage

// File: rtl/mac_kern_sched_tap_addr_gen.sv
// Maps (oy, ox, tap) to a row-major feature address plus pad flag, registered
// so the address lines up with the feature buffer read enable.
module tap_addr_gen
  import mac_kern_sched_pkg::*;
#(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 2 * DIM_W,
  parameter int TAP_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en_i,
  input  logic              is_conv3x3_i,
  input  logic [DIM_W-1:0]  oy_i,
  input  logic [DIM_W-1:0]  ox_i,
  input  logic [TAP_W-1:0]  tap_i,
  input  logic [DIM_W-1:0]  height_i,
  input  logic [DIM_W-1:0]  width_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              pad_o
);

  logic [3:0]        t4, ky4;
  logic [1:0]        ky, kx;
  logic [DIM_W+1:0]  ry, rx;
  pad_e              pad_d, pad_q;
  logic [ADDR_W-1:0] addr_d, addr_q;

  // Two guard bits: the MSB flags a -1 row/col, the next holds oy+2.
  always_comb begin
    t4    = 4'(tap_i);
    ky    = tap_ky(t4);
    ky4   = {2'b00, ky};
    kx    = 2'(t4 - (ky4 << 1) - ky4);
    ry    = {2'b00, oy_i} + {{DIM_W{1'b0}}, ky};
    rx    = {2'b00, ox_i} + {{DIM_W{1'b0}}, kx};
    pad_d = PAD_NONE;
    if (PAD_EN && is_conv3x3_i) begin
      ry    = ry - (DIM_W+2)'(1);
      rx    = rx - (DIM_W+2)'(1);
      pad_d = pad_e'(ry[DIM_W+1] | rx[DIM_W+1] |
                     (ry >= {2'b00, height_i}) | (rx >= {2'b00, width_i}));
    end
    addr_d = (pad_d == PAD_ZERO) ? '0
           : ADDR_W'(ry) * ADDR_W'(width_i) + ADDR_W'(rx);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q <= '0;
      pad_q  <= PAD_NONE;
    end else if (en_i) begin
      addr_q <= addr_d;
      pad_q  <= pad_d;
    end else begin
      addr_q <= '0;
      pad_q  <= PAD_NONE;
    end
  end

  assign addr_o = addr_q;
  assign pad_o  = (pad_q == PAD_ZERO);

endmodule

// File: rtl/mac_kern_sched.sv
// Job scheduler for the conv MAC kernel: issues one feature/weight beat per cycle
// and counts kernel results to detect completion. Padding via MAC_SCHED_PAD_EN.
module mac_kern_sched
  import mac_kern_sched_pkg::*;
#(
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 2 * DIM_W,
  parameter int TAP_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              is_conv3x3_i,
  input  logic [DIM_W-1:0]  height_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic              hold_i,
  output logic              fbuf_rd_o,
  output logic [ADDR_W-1:0] fbuf_addr_o,
  output logic [TAP_W-1:0]  wbuf_addr_o,
  output logic              pad_o,
  output logic              mac_vld_o,
  output logic              mac_is_conv3x3_o,
  input  logic              acc_vld_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o
);

  state_e            state_q;
  logic              conv3_q, mode_q, busy_q, done_q, cfg_err_q, pad_q;
  logic [DIM_W-1:0]  h_q, w_q, oh_q, ow_q, oy_q, ox_q;
  logic [TAP_W-1:0]  t_q, wtap_q;
  logic [ADDR_W-1:0] acc_cnt_q, acc_cnt_d, total;
  logic [1:0]        vld_pipe_q;

  logic cfg_bad, issue, last_tap, last_pix, gen_pad;

  always_comb begin
    cfg_bad   = (height_i == '0) || (width_i == '0) ||
                (is_conv3x3_i && !PAD_EN &&
                 ((height_i < DIM_W'(3)) || (width_i < DIM_W'(3))));
    // A hold only stalls before tap 0; a started pixel always runs out.
    issue     = (state_q == S_ISSUE) && !((t_q == '0) && hold_i);
    last_tap  = (t_q == (conv3_q ? TAP_W'(NUM_TAPS-1) : '0));
    last_pix  = (oy_q == oh_q - DIM_W'(1)) && (ox_q == ow_q - DIM_W'(1));
    total     = ADDR_W'(oh_q) * ADDR_W'(ow_q);
    acc_cnt_d = acc_cnt_q + ADDR_W'(acc_vld_i);
  end

  tap_addr_gen #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .TAP_W(TAP_W)) u_tap_addr_gen (
    .clk          (clk),
    .rstn         (rstn),
    .en_i         (issue),
    .is_conv3x3_i (conv3_q),
    .oy_i         (oy_q),
    .ox_i         (ox_q),
    .tap_i        (t_q),
    .height_i     (h_q),
    .width_i      (w_q),
    .addr_o       (fbuf_addr_o),
    .pad_o        (gen_pad)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      conv3_q    <= 1'b0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      pad_q      <= 1'b0;
      h_q        <= '0;
      w_q        <= '0;
      oh_q       <= '0;
      ow_q       <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      t_q        <= '0;
      wtap_q     <= '0;
      acc_cnt_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      cfg_err_q  <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe_q <= {vld_pipe_q[0], issue};
      pad_q      <= gen_pad;
      wtap_q     <= issue ? t_q : '0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              state_q   <= S_ISSUE;
              conv3_q   <= is_conv3x3_i;
              mode_q    <= is_conv3x3_i;
              busy_q    <= 1'b1;
              h_q       <= height_i;
              w_q       <= width_i;
              oh_q      <= (is_conv3x3_i && !PAD_EN) ? height_i - DIM_W'(2) : height_i;
              ow_q      <= (is_conv3x3_i && !PAD_EN) ? width_i - DIM_W'(2) : width_i;
              oy_q      <= '0;
              ox_q      <= '0;
              t_q       <= '0;
              acc_cnt_q <= '0;
            end
          end
        end
        S_ISSUE: begin
          acc_cnt_q <= acc_cnt_d;
          if (issue) begin
            if (last_tap) begin
              t_q <= '0;
              if (last_pix) begin
                state_q <= S_DRAIN;
              end else if (ox_q == ow_q - DIM_W'(1)) begin
                ox_q <= '0;
                oy_q <= oy_q + DIM_W'(1);
              end else begin
                ox_q <= ox_q + DIM_W'(1);
              end
            end else begin
              t_q <= t_q + TAP_W'(1);
            end
          end
        end
        S_DRAIN: begin
          acc_cnt_q <= acc_cnt_d;
          if (acc_cnt_d == total) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          mode_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fbuf_rd_o        = vld_pipe_q[0];
  assign mac_vld_o        = vld_pipe_q[1];
  assign wbuf_addr_o      = wtap_q;
  assign pad_o            = pad_q;
  assign mac_is_conv3x3_o = mode_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign cfg_err_o        = cfg_err_q;

endmodule

// File: tb/tb_mac_kern_sched.sv
// Randomized bench for mac_kern_sched against a queue-based beat/result model.
module tb_mac_kern_sched;

  localparam int DIM_W  = 8;
  localparam int ADDR_W = 16;
  localparam int TAP_W  = 4;
`ifdef MAC_SCHED_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn, start_i, is_conv3x3_i, hold_i, acc_vld_i;
  logic [DIM_W-1:0]  height_i, width_i;
  logic              fbuf_rd_o, pad_o, mac_vld_o, mac_is_conv3x3_o;
  logic              busy_o, done_o, cfg_err_o;
  logic [ADDR_W-1:0] fbuf_addr_o;
  logic [TAP_W-1:0]  wbuf_addr_o;

  always #5 clk = ~clk;

  mac_kern_sched #(.DIM_W(DIM_W), .ADDR_W(ADDR_W), .TAP_W(TAP_W)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .is_conv3x3_i(is_conv3x3_i),
    .height_i(height_i), .width_i(width_i), .hold_i(hold_i),
    .fbuf_rd_o(fbuf_rd_o), .fbuf_addr_o(fbuf_addr_o), .wbuf_addr_o(wbuf_addr_o),
    .pad_o(pad_o), .mac_vld_o(mac_vld_o), .mac_is_conv3x3_o(mac_is_conv3x3_o),
    .acc_vld_i(acc_vld_i), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int addr;
    int tap;
    bit pad;
    bit last;
  } beat_t;

  beat_t exp_q[$];

  // Expected beat stream in issue order; returns the number of output pixels.
  function automatic int build(bit c3, int h, int w);
    int oh = h;
    int ow = w;
    int nt = c3 ? 9 : 1;
    int off = (c3 && PAD) ? 1 : 0;
    exp_q.delete();
    if (c3 && !PAD) begin
      oh = h - 2;
      ow = w - 2;
    end
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int t = 0; t < nt; t++) begin
          beat_t b;
          int sy = oy + t / 3 - off;
          int sx = ox + t % 3 - off;
          b.pad  = (sy < 0) || (sy >= h) || (sx < 0) || (sx >= w);
          b.addr = b.pad ? 0 : sy * w + sx;
          b.tap  = t;
          b.last = (t == nt - 1);
          exp_q.push_back(b);
        end
    return oh * ow;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rd"},   32'(fbuf_rd_o),        32'(0));
    chk({tag, "_fa"},   32'(fbuf_addr_o),      32'(0));
    chk({tag, "_wa"},   32'(wbuf_addr_o),      32'(0));
    chk({tag, "_pad"},  32'(pad_o),            32'(0));
    chk({tag, "_vld"},  32'(mac_vld_o),        32'(0));
    chk({tag, "_mode"}, 32'(mac_is_conv3x3_o), 32'(0));
    chk({tag, "_busy"}, 32'(busy_o),           32'(0));
    chk({tag, "_done"}, 32'(done_o),           32'(0));
    chk({tag, "_err"},  32'(cfg_err_o),        32'(0));
  endtask

  task automatic run_job(input bit c3, input int h, input int w, input int hold_pct, input bit junk);
    int    total, idx, got, pend;
    bit    prev_rd, h_now, a_now, done_seen;
    beat_t prev;
    total = build(c3, h, w);
    idx = 0; got = 0; pend = 0; prev_rd = 0; done_seen = 0;
    prev = '{0, 0, 1'b0, 1'b0};
    start_i = 1'b1; is_conv3x3_i = c3;
    height_i = 8'(h); width_i = 8'(w);
    hold_i = 1'b0; acc_vld_i = 1'b0;
    tick();
    chk("start_busy", 32'(busy_o), 32'(1));
    chk("start_rd", 32'(fbuf_rd_o), 32'(0));
    chk("start_mode", 32'(mac_is_conv3x3_o), 32'(c3));
    start_i = 1'b0;
    for (int cyc = 0; cyc < 5000 && !done_seen; cyc++) begin
      h_now = ($urandom_range(0, 99) < hold_pct);
      a_now = (pend > 0) && ($urandom_range(0, 1) == 1);
      if (a_now) pend--;
      hold_i = h_now;
      acc_vld_i = a_now;
      if (junk) begin
        start_i = 1'($urandom);
        is_conv3x3_i = 1'($urandom);
        height_i = 8'($urandom);
        width_i = 8'($urandom);
      end
      tick();
      if (a_now) got++;
      chk("mac_vld", 32'(mac_vld_o), 32'(prev_rd));
      if (prev_rd) begin
        chk("pad", 32'(pad_o), 32'(prev.pad));
        chk("mode", 32'(mac_is_conv3x3_o), 32'(c3));
        if (prev.last) pend++;
      end
      if (idx < exp_q.size() && !(exp_q[idx].tap == 0 && h_now)) begin
        chk("rd", 32'(fbuf_rd_o), 32'(1));
        chk("faddr", 32'(fbuf_addr_o), exp_q[idx].addr);
        chk("waddr", 32'(wbuf_addr_o), exp_q[idx].tap);
        prev = exp_q[idx];
        prev_rd = 1'b1;
        idx++;
      end else begin
        chk("rd_idle", 32'(fbuf_rd_o), 32'(0));
        prev_rd = 1'b0;
      end
      chk("busy", 32'(busy_o), 32'(1));
      if (got == total && a_now) begin
        chk("done", 32'(done_o), 32'(1));
        done_seen = 1'b1;
      end else begin
        chk("no_done", 32'(done_o), 32'(0));
      end
    end
    if (!done_seen) chk("job_timeout", 32'(0), 32'(1));
    start_i = 1'b0; hold_i = 1'b0; acc_vld_i = 1'b0;
    tick();
    chk("post_busy", 32'(busy_o), 32'(0));
    chk("post_done", 32'(done_o), 32'(0));
    chk("post_mode", 32'(mac_is_conv3x3_o), 32'(0));
  endtask

  task automatic cfg_err_case(input bit c3, input int h, input int w);
    start_i = 1'b1; is_conv3x3_i = c3;
    height_i = 8'(h); width_i = 8'(w);
    tick();
    start_i = 1'b0;
    chk("err_pulse", 32'(cfg_err_o), 32'(1));
    chk("err_busy", 32'(busy_o), 32'(0));
    chk("err_rd", 32'(fbuf_rd_o), 32'(0));
    tick();
    chk("err_clear", 32'(cfg_err_o), 32'(0));
    chk("err_busy2", 32'(busy_o), 32'(0));
    chk("err_rd2", 32'(fbuf_rd_o), 32'(0));
  endtask

  task automatic reset_mid_job();
    start_i = 1'b1; is_conv3x3_i = 1'b1;
    height_i = 8'd4; width_i = 8'd4; hold_i = 1'b0; acc_vld_i = 1'b0;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    chk("rst_pre_rd", 32'(fbuf_rd_o), 32'(1));
    rstn = 1'b0;
    acc_vld_i = 1'b1;
    tick();
    chk_quiet("rst_mid");
    rstn = 1'b1;
    repeat (3) tick();
    acc_vld_i = 1'b0;
    chk_quiet("rst_after");
  endtask

  initial begin
    rstn = 1'b0; start_i = 1'b0; is_conv3x3_i = 1'b0; hold_i = 1'b0;
    acc_vld_i = 1'b0; height_i = '0; width_i = '0;
    tick();
    tick();
    chk_quiet("reset");
    rstn = 1'b1;
    tick();

    run_job(1'b0, 2, 3, 0, 1'b0);
    run_job(1'b1, 3, 3, 0, 1'b0);
    run_job(1'b1, 4, 5, 0, 1'b0);
    run_job(1'b1, 3, 4, 40, 1'b0);
    run_job(1'b0, 1, 1, 0, 1'b0);

    cfg_err_case(1'b0, 0, 5);
    cfg_err_case(1'b0, 4, 0);
    cfg_err_case(1'b1, 0, 3);
    if (PAD) begin
      run_job(1'b1, 2, 2, 20, 1'b0);
      run_job(1'b1, 1, 3, 20, 1'b0);
    end else begin
      cfg_err_case(1'b1, 2, 5);
      cfg_err_case(1'b1, 5, 2);
    end

    run_job(1'b0, 4, 4, 30, 1'b1);
    reset_mid_job();
    run_job(1'b1, 4, 3, 10, 1'b0);

    for (int j = 0; j < 8; j++) begin
      bit c3 = 1'($urandom);
      int lo = (c3 && !PAD) ? 3 : 1;
      run_job(c3, int'($urandom_range(lo, 7)), int'($urandom_range(lo, 7)),
              25, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
